fp_matmul_seq: RTL and testbench
================================

# fp_matmul_seq

Sequential, parametrised signed fixed-point matrix multiplier: OUT[ROW_1×COL_2] = IN_1[ROW_1×COL_1] × IN_2[COL_1×COL_2]. It is the multi-cycle successor to the combinational FPMatMul used in the attention datapath. It uses a ROW_1×COL_2 MAC array that performs one outer product per cycle, and adds valid/ready handshakes on input and output. It supports optional accumulation across successive calls, for K-tiling, plus round-half-up and saturation on output.

## Interface
- DATA_WIDTH, 16, element width, signed two's complement
- FRAC_BITS, 8, fractional bits of inputs and outputs (Q8.8 at defaults)
- ROW_1, 4, rows of IN_1 and OUT
- COL_1, 4, columns of IN_1 = rows of IN_2 (reduction depth K); ≥1
- COL_2, 2, columns of IN_2 and OUT
- ACC_WIDTH, 40, accumulator width; must be ≥ 2*DATA_WIDTH+clog2(COL_1)+1

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand set valid
- in_ready  out  1  block can accept operands
- in_accum  in  1  sampled with input handshake: 1 = start from retained accumulators, 0 = start from zero
- in_1  in  DATA_WIDTH*ROW_1*COL_1  element (r,c) at [DATA_WIDTH*(r*COL_1+c) +: DATA_WIDTH]
- in_2  in  DATA_WIDTH*COL_1*COL_2  element (r,c) at [DATA_WIDTH*(r*COL_2+c) +: DATA_WIDTH]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out  out  DATA_WIDTH*ROW_1*COL_2  element (r,c) at [DATA_WIDTH*(r*COL_2+c) +: DATA_WIDTH]

## Operation
- FSM states: IDLE, CALC, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- IDLE, on an edge with in_valid && in_ready:
  - Latch in_1 and in_2 into operand registers.
  - k ← 0.
  - Each acc[r][c] ← 0 if in_accum=0; unchanged if in_accum=1.
  - State → CALC.
- CALC, each edge:
  - acc[r][c] += sext(A[r][k]) * sext(B[k][c]) for all r,c. Product is full 2*DATA_WIDTH signed, sign-extended to ACC_WIDTH.
  - k ← k+1.
  - On the edge where k==COL_1-1, state → DONE.
- DONE:
  - out is derived combinationally from acc.
  - Rounding: t = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS, arithmetic shift, round half up toward +∞.
  - Saturation: t > 2^(DATA_WIDTH-1)-1 → 0x7FFF; t < -2^(DATA_WIDTH-1) → 0x8000 (16-bit defaults).
  - On an edge with out_ready, state → IDLE. Accumulators are retained for a later in_accum=1 call.
- Accumulators wrap modulo 2^ACC_WIDTH. The ACC_WIDTH constraint makes wrap impossible for one call. Saturation applies only at output.
- Operand changes on in_1/in_2 after acceptance have no effect.

## Timing
- Reset values (asynchronous):
  - state=IDLE, in_ready=1, out_valid=0, k=0.
  - All acc=0, so out reads 0 (but out is don't-care while out_valid=0).
  - Operand registers = 0.
- Latency: out_valid rises exactly COL_1 clock edges after the accepting edge.
- Throughput: at most one operand set per COL_1+2 cycles when out_ready is held high.
  - 1 accept edge, COL_1 CALC edges, 1 DONE edge with out_ready.
  - No overlap: in_ready stays low in CALC and DONE.
- out and out_valid stay stable while out_valid=1 && out_ready=0, for any duration.
- in_valid during CALC/DONE is ignored. The source must hold in_valid until in_ready.
- out_ready while out_valid=0 is ignored.
- Reset asserted mid-CALC or mid-DONE aborts immediately.
  - On release: state=IDLE, accumulators zero.
  - A subsequent in_accum=1 call therefore starts from zero.
- COL_1=1: CALC lasts one edge, so out_valid rises 1 edge after accept.

## Test plan
- Identity (defaults): in_1=I4 (diagonal 0x0100), in_2 rows {0x0100,0x0200},{0x0080,0xFF00},{0x0300,0x0040},{0x0000,0x7FFF} → out equals in_2 exactly. out_valid high exactly 4 edges after accept.
- Rounding: all in_1=0x0001, in_2[0][*]=0x0080, other rows 0 → every out = 0x0001 (raw 128 rounds up). Repeat with 0x007F → 0x0000. Repeat with in_2=0xFF80 (-0.5 ulp case, raw -128) → 0x0000.
- Saturation: in_1 all 0x7F00, in_2 all 0x7F00 → all out 0x7FFF. With in_2 all 0x8100 → all out 0x8000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - out is stable and in_ready=0 throughout.
  - A concurrent in_valid pulse is not accepted.
  - out_ready=1 → IDLE next edge, in_ready=1.
- Accumulate: identity × B with in_accum=0, then the same operands with in_accum=1 → second result = 2×B. For B=0x4000, second result saturates to 0x7FFF.
- Reset mid-CALC: assert rst_n=0 after 2 CALC edges.
  - Outputs go immediately to in_ready=1, out_valid=0.
  - A following in_accum=1 identity×B call returns B, not 2×B.

Source files
------------

// File: rtl/fp_matmul_seq.sv
// fp_matmul_seq: sequential signed fixed-point matrix multiply OUT = IN_1 x IN_2, one outer product per cycle.
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake; in_accum sampled with it (1 = keep accumulators, 0 = clear)
//   in_1, in_2          row-major packed operand matrices (ROW_1 x COL_1, COL_1 x COL_2)
//   out_valid/out_ready result handshake; out is the rounded, saturated ROW_1 x COL_2 result
module fp_matmul_seq #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8,
   parameter int ROW_1      = 4,
   parameter int COL_1      = 4,
   parameter int COL_2      = 2,
   parameter int ACC_WIDTH  = 40
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic                              in_accum,
   input  logic [DATA_WIDTH*ROW_1*COL_1-1:0] in_1,
   input  logic [DATA_WIDTH*COL_1*COL_2-1:0] in_2,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [DATA_WIDTH*ROW_1*COL_2-1:0] out
);
   localparam int KW = COL_1 > 1 ? $clog2(COL_1) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(COL_1 - 1);
   localparam logic signed [ACC_WIDTH-1:0] HALF  = ACC_WIDTH'(1) << (FRAC_BITS - 1);
   localparam logic signed [ACC_WIDTH-1:0] MAX_V = (ACC_WIDTH'(1) << (DATA_WIDTH - 1)) - ACC_WIDTH'(1);
   localparam logic signed [ACC_WIDTH-1:0] MIN_V = ~MAX_V;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_d;
   logic [KW-1:0] k;
   logic signed [DATA_WIDTH-1:0] a_q [ROW_1][COL_1];
   logic signed [DATA_WIDTH-1:0] b_q [COL_1][COL_2];
   logic accept;
   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   assign accept    = in_valid && in_ready;
   always_comb begin
      state_d = state;
      if (state == IDLE && in_valid) state_d = CALC;
      else if (state == CALC && k == K_LAST) state_d = DONE;
      else if (state == DONE && out_ready) state_d = IDLE;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         k     <= '0;
         a_q   <= '{default: '0};
         b_q   <= '{default: '0};
      end else begin
         state <= state_d;
         if (accept) begin
            k <= '0;
            for (int r = 0; r < ROW_1; r++)
               for (int c = 0; c < COL_1; c++)
                  a_q[r][c] <= in_1[DATA_WIDTH*(r*COL_1+c) +: DATA_WIDTH];
            for (int r = 0; r < COL_1; r++)
               for (int c = 0; c < COL_2; c++)
                  b_q[r][c] <= in_2[DATA_WIDTH*(r*COL_2+c) +: DATA_WIDTH];
         end else if (state == CALC) begin
            k <= k + KW'(1);
         end
      end
   for (genvar r = 0; r < ROW_1; r++) begin : g_r
      for (genvar c = 0; c < COL_2; c++) begin : g_c
         logic signed [2*DATA_WIDTH-1:0] p;
         logic signed [ACC_WIDTH-1:0]    acc, t;
         assign p = a_q[r][k] * b_q[k][c];
         // the accumulator wraps freely; clamping happens only on the rounded output
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) acc <= '0;
            else if (accept && !in_accum) acc <= '0;
            else if (state == CALC) acc <= acc + ACC_WIDTH'(p);
         assign t = (acc + HALF) >>> FRAC_BITS;
         assign out[DATA_WIDTH*(r*COL_2+c) +: DATA_WIDTH] =
            t > MAX_V ? {1'b0, {(DATA_WIDTH-1){1'b1}}} :
            t < MIN_V ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : t[DATA_WIDTH-1:0];
      end
   end
endmodule

// File: tb/tb_fp_matmul_seq.sv
// tb_fp_matmul_seq: directed table-driven bench for fp_matmul_seq at default parameters.
module tb_fp_matmul_seq;
   localparam int AW = 256;
   localparam int BW = 128;
   localparam int OW = 128;
   typedef struct {
      string         name;
      logic [AW-1:0] a;
      logic [BW-1:0] b;
      logic          accum;
      logic [OW-1:0] exp;
   } vec_t;
   logic clk = 0, rst_n = 0, in_valid = 0, in_accum = 0, out_ready = 0;
   logic in_ready, out_valid;
   logic [AW-1:0] in_1 = '0;
   logic [BW-1:0] in_2 = '0;
   logic [OW-1:0] out;
   int tests = 0, fails = 0;
   vec_t vecs [11];
   fp_matmul_seq dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_accum(in_accum),
      .in_1(in_1), .in_2(in_2), .out_valid(out_valid), .out_ready(out_ready), .out(out)
   );
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
   task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   function automatic logic [AW-1:0] perm_a(input int sh);
      logic [AW-1:0] v = '0;
      for (int r = 0; r < 4; r++) v[16*(r*4+(r+sh)%4) +: 16] = 16'h0100;
      return v;
   endfunction
   function automatic logic [AW-1:0] fill_a(input logic [15:0] x);
      logic [AW-1:0] v;
      for (int i = 0; i < 16; i++) v[16*i +: 16] = x;
      return v;
   endfunction
   function automatic logic [BW-1:0] fill_b(input logic [15:0] x);
      logic [BW-1:0] v;
      for (int i = 0; i < 8; i++) v[16*i +: 16] = x;
      return v;
   endfunction
   function automatic logic [BW-1:0] row0_b(input logic [15:0] x);
      logic [BW-1:0] v = '0;
      v[31:0] = {x, x};
      return v;
   endfunction
   function automatic logic [BW-1:0] mat(input logic [15:0] e [8]);
      logic [BW-1:0] v;
      for (int i = 0; i < 8; i++) v[16*i +: 16] = e[i];
      return v;
   endfunction
   task automatic start(input logic [AW-1:0] a, input logic [BW-1:0] b, input logic acc);
      @(negedge clk);
      chk("in_ready_before_accept", AW'(in_ready), AW'(1));
      in_1 = a; in_2 = b; in_accum = acc; in_valid = 1;
      @(posedge clk);
      #1;
      in_valid = 0; in_1 = ~a; in_2 = ~b; in_accum = ~acc;
   endtask
   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask
   task automatic release_out;
      @(negedge clk);
      out_ready = 1;
      @(posedge clk);
      #1;
      out_ready = 0;
   endtask
   initial begin
      logic [15:0] b1e [8];
      logic [15:0] pe [8];
      logic [BW-1:0] b1, snap;
      int lat;
      b1e = '{16'h0100, 16'h0200, 16'h0080, 16'hFF00, 16'h0300, 16'h0040, 16'h0000, 16'h7FFF};
      pe  = '{16'h0080, 16'hFF00, 16'h0300, 16'h0040, 16'h0000, 16'h7FFF, 16'h0100, 16'h0200};
      b1 = mat(b1e);
      vecs[0]  = '{"identity",      perm_a(0),        b1,                 1'b0, b1};
      vecs[1]  = '{"permute_rows",  perm_a(1),        b1,                 1'b0, mat(pe)};
      vecs[2]  = '{"round_up_half", fill_a(16'h0001), row0_b(16'h0080),   1'b0, fill_b(16'h0001)};
      vecs[3]  = '{"round_down",    fill_a(16'h0001), row0_b(16'h007F),   1'b0, fill_b(16'h0000)};
      vecs[4]  = '{"round_neg_half",fill_a(16'h0001), row0_b(16'hFF80),   1'b0, fill_b(16'h0000)};
      vecs[5]  = '{"sat_pos",       fill_a(16'h7F00), fill_b(16'h7F00),   1'b0, fill_b(16'h7FFF)};
      vecs[6]  = '{"sat_neg",       fill_a(16'h7F00), fill_b(16'h8100),   1'b0, fill_b(16'h8000)};
      vecs[7]  = '{"acc_base_4000", perm_a(0),        fill_b(16'h4000),   1'b0, fill_b(16'h4000)};
      vecs[8]  = '{"acc_sat_4000",  perm_a(0),        fill_b(16'h4000),   1'b1, fill_b(16'h7FFF)};
      vecs[9]  = '{"acc_base_0180", perm_a(0),        fill_b(16'h0180),   1'b0, fill_b(16'h0180)};
      vecs[10] = '{"acc_dbl_0180",  perm_a(0),        fill_b(16'h0180),   1'b1, fill_b(16'h0300)};
      #12;
      chk("reset_in_ready", AW'(in_ready), AW'(1));
      chk("reset_out_valid", AW'(out_valid), AW'(0));
      chk("reset_out", AW'(out), AW'(0));
      rst_n = 1;
      for (int i = 0; i < 11; i++) begin
         start(vecs[i].a, vecs[i].b, vecs[i].accum);
         wait_out(lat);
         chk({vecs[i].name, "_latency"}, AW'(lat), AW'(4));
         chk(vecs[i].name, AW'(out), AW'(vecs[i].exp));
         release_out();
         chk({vecs[i].name, "_back_idle"}, AW'({in_ready, out_valid}), AW'(2'b10));
      end
      // backpressure with a stray in_valid pulse while the result is held
      start(perm_a(0), b1, 1'b0);
      wait_out(lat);
      snap = out;
      chk("bp_first", AW'(snap), AW'(b1));
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = i == 2; in_1 = fill_a(16'h7F00); in_2 = fill_b(16'h7F00); in_accum = 0;
         @(posedge clk);
         #1;
         chk("bp_out_stable", AW'(out), AW'(b1));
         chk("bp_handshake", AW'({in_ready, out_valid}), AW'(2'b01));
      end
      in_valid = 0;
      release_out();
      chk("bp_release_idle", AW'({in_ready, out_valid}), AW'(2'b10));
      @(negedge clk);
      chk("bp_pulse_ignored", AW'({in_ready, out_valid}), AW'(2'b10));
      // reset mid-CALC clears the accumulators retained from the last call
      start(perm_a(0), fill_b(16'h0180), 1'b0);
      wait_out(lat);
      release_out();
      start(perm_a(0), fill_b(16'h0180), 1'b1);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 0;
      #1;
      chk("rst_mid_calc", AW'({in_ready, out_valid}), AW'(2'b10));
      @(negedge clk);
      rst_n = 1;
      start(perm_a(0), fill_b(16'h0180), 1'b1);
      wait_out(lat);
      chk("rst_accum_latency", AW'(lat), AW'(4));
      chk("rst_accum_from_zero", AW'(out), AW'(fill_b(16'h0180)));
      release_out();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
